// File: rtl/seq_mux_scan.sv
// Registered N-channel W-bit selector with manual select and round-robin auto-scan.
// Scan mode holds each channel for DWELL samples and pulses wrap on return to channel 0.
module seq_mux_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      en,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  output logic [SEL_W-1:0]          ch,
  output logic                      wrap,
  output logic                      sel_err
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W:0]   CH_LIM     = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(CHANNELS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MANUAL = 2'd1,
    S_SCAN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  y_q, y_d;
  logic              y_valid_q, y_valid_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic              wrap_q, wrap_d;
  logic              sel_err_q, sel_err_d;
  logic [SEL_W-1:0]  scan_ch_q, scan_ch_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;

  logic              sel_ok;
  logic              entering;
  logic [SEL_W-1:0]  cur;
  logic [DW_W-1:0]   cnt;

  // Out-of-range indices never reach a din slice; they fall through to zero.
  function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] d,
                                            input logic [SEL_W-1:0]          idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) r = d[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] c);
    return (c == CH_LAST) ? '0 : c + SEL_W'(1);
  endfunction

  assign sel_ok = {1'b0, sel} < CH_LIM;

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    ch_d      = ch_q;
    wrap_d    = 1'b0;
    sel_err_d = sel_err_q;
    scan_ch_d = scan_ch_q;
    dwell_d   = '0;
    entering  = 1'b0;
    cur       = scan_ch_q;
    cnt       = dwell_q;

    if (!en) begin
      state_d = S_IDLE;
    end else if (!mode) begin
      state_d = S_MANUAL;
      if (sel_ok) begin
        y_d       = pick(din, sel);
        ch_d      = sel;
        y_valid_d = 1'b1;
        sel_err_d = 1'b0;
      end else begin
        sel_err_d = 1'b1;
      end
    end else begin
      state_d  = S_SCAN;
      // Any entry into scan restarts it; the previous position is never resumed.
      entering = (state_q != S_SCAN);
      if (entering) begin
        cur = sel_ok ? sel : '0;
        cnt = '0;
      end
      y_d       = pick(din, cur);
      ch_d      = cur;
      y_valid_d = 1'b1;
      sel_err_d = 1'b0;
      // A zero dwell count outside entry means we just advanced; landing on 0 is a wrap.
      wrap_d    = !entering && (cnt == '0) && (cur == '0);
      if (cnt == DWELL_LAST) begin
        dwell_d   = '0;
        scan_ch_d = next_ch(cur);
      end else begin
        dwell_d   = cnt + DW_W'(1);
        scan_ch_d = cur;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      ch_q      <= '0;
      wrap_q    <= 1'b0;
      sel_err_q <= 1'b0;
      scan_ch_q <= '0;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      ch_q      <= ch_d;
      wrap_q    <= wrap_d;
      sel_err_q <= sel_err_d;
      scan_ch_q <= scan_ch_d;
      dwell_q   <= dwell_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign ch      = ch_q;
  assign wrap    = wrap_q;
  assign sel_err = sel_err_q;

endmodule

// File: doc/seq_mux_scan.md
Name: seq_mux_scan

Overview:
- Registered, parametrised N-channel, W-bit selector.
- Generalises the single-bit 2:1 select expression to CHANNELS inputs of WIDTH bits each.
- Adds a clocked output and an auto-scan mode that steps round-robin through the channels, with a programmable dwell time per channel.
- Sits between multi-source datapaths and a single consumer: debug/monitor taps and time-multiplexed sampling.

Parameters:
- WIDTH, 8, bit width of each channel and of the output.
- CHANNELS, 4, number of input channels; must be >= 2.
- SEL_W, 2, select/channel index width; must be >= ceil(log2(CHANNELS)).
- DWELL, 4, cycles spent on each channel in scan mode; must be >= 1.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- din  input  CHANNELS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  manual channel select.
- mode  input  1  0 = manual, 1 = auto-scan.
- en  input  1  block enable.
- y  output  WIDTH  registered selected data.
- y_valid  output  1  y holds a freshly captured sample this cycle.
- ch  output  SEL_W  channel index that y was captured from.
- wrap  output  1  one-cycle pulse when scan advances from channel CHANNELS-1 to channel 0.
- sel_err  output  1  registered flag: manual sel >= CHANNELS.

Behaviour:
- Clock and reset:
  - All state updates occur on the rising edge of clk. Reset is synchronous and active-high.
  - While rst = 1, on each edge: y = 0, y_valid = 0, ch = 0, wrap = 0, sel_err = 0, state = IDLE, dwell counter = 0.
  - rst has priority over all other inputs, including mid-scan; the scan position is lost.
- FSM states:
  - IDLE: entered from any state when en = 0 at the edge. y and ch hold their values. y_valid = 0, wrap = 0. sel_err holds.
  - MANUAL: entered when en = 1 and mode = 0.
    - Each cycle with sel < CHANNELS: y <= din[sel], ch <= sel, y_valid <= 1, sel_err <= 0.
    - Each cycle with sel >= CHANNELS: y and ch hold, y_valid <= 0, sel_err <= 1.
    - Latency is 1 cycle from sel/din to y.
  - SCAN: entered when en = 1 and mode = 1.
    - On entry, the start channel is sel if sel < CHANNELS, else 0. The dwell counter clears to 0.
    - Each cycle: y <= din[ch_cur], ch <= ch_cur, y_valid <= 1. din is re-sampled every cycle, not only on channel change.
    - The dwell counter increments each cycle. When it reaches DWELL-1, it clears and ch_cur advances on the next cycle:
      - ch_cur+1 if ch_cur < CHANNELS-1;
      - otherwise 0, and wrap pulses 1 for exactly one cycle, coincident with the first y sample from channel 0.
    - DWELL = 1 advances ch_cur every cycle.
    - sel_err is forced to 0 in SCAN.
- Transitions:
  - Mode change takes effect at the next edge; there is no drain cycle.
  - SCAN -> MANUAL: the next y comes from sel.
  - MANUAL -> SCAN: restarts the scan per the entry rule.
  - IDLE -> SCAN restarts the scan. A pause via en does not resume the old position.
  - en = 0 at the same edge as a mode change: IDLE wins.
- Width rules:
  - Only the low SEL_W bits of indices are used.
  - When CHANNELS is not a power of two, ch never exceeds CHANNELS-1 in SCAN.
- Simultaneous events:
  - A dwell expiry coinciding with en falling: the advance is discarded and no wrap is produced.

Test Plan:
All scenarios use WIDTH=8, CHANNELS=4, DWELL=2, din = {8'h44, 8'h33, 8'h22, 8'h11}.
1. Reset: hold rst = 1 for 2 cycles with en = 1, mode = 1 -> y = 00, y_valid = 0, ch = 0, wrap = 0, sel_err = 0.
2. Manual sweep: en = 1, mode = 0, sel = 0,1,2,3 on successive cycles -> one cycle later y = 11,22,33,44, ch = 0..3, y_valid = 1.
3. Manual out-of-range (CHANNELS = 3 build, sel = 3 after sel = 1) -> y holds 22, y_valid = 0, sel_err = 1. Then sel = 2 -> y = 33, sel_err = 0.
4. Scan from sel = 2: mode = 1 -> y sequence 33,33,44,44,11,11,22,22,33. wrap = 1 only on the first 11 cycle.
5. Pause/restart: in scan, drop en for 3 cycles while y = 44 -> y holds 44, y_valid = 0. Raise en with sel = 0 -> scan restarts at 11 with the dwell counter cleared.
6. Mid-scan reset: assert rst on the wrap cycle -> next cycle all outputs are 0. Release rst, mode = 1, sel = 1 -> y = 22 one cycle later.
